if_pc_sequencer: RTL and testbench
==================================

// Module: if_pc_sequencer
// PURPOSE
//   Fetch-stage program-counter unit for the pipelined RISC-V core. Holds the PC register and
//   selects the next PC from NUM_REDIR prioritised redirect channels (trap, EX branch, ID jump)
//   or sequential PC+PC_STEP. Redirects that arrive during a stall are buffered and applied on
//   release. Replaces ad-hoc 2:1 next-PC muxing with one registered, parametrised block.
// PARAMETERS
//   XLEN          32            PC / target width
//   NUM_REDIR     3             redirect channels; index 0 = highest priority
//   PC_STEP       4             sequential increment (bytes)
//   RESET_VECTOR  32'h0000_0000 PC value held in reset and issued first after reset
//   TRAP_VECTOR   32'h0000_0100 target used on misaligned redirect (IF_PC_ALIGN_CHECK_EN only)
// PORTS
//   clk            in   1                rising-edge clock
//   reset          in   1                synchronous, active-high reset
//   stall          in   1                hold PC (hazard unit / I-mem not ready)
//   redir_valid    in   NUM_REDIR        per-channel redirect request
//   redir_target   in   NUM_REDIR*XLEN   channel i target at [i*XLEN +: XLEN]
//   pc             out  XLEN             current fetch address (registered)
//   pc_valid       out  1                pc is a real fetch address
//   redir_pending  out  1                a buffered redirect awaits stall release
//   misalign_err   out  1                one-cycle pulse: misaligned redirect trapped
// BEHAVIOUR
//   Reset (reset=1 at a clk edge): pc=RESET_VECTOR, pc_valid=0, redir_pending=0,
//     misalign_err=0, state=BOOT. Reset overrides every other input, including mid-stall/pending.
//   States: BOOT, RUN, HOLD.
//   BOOT: next edge -> RUN, pc_valid=1, pc stays RESET_VECTOR (first fetch at reset vector);
//     redirects/stall in BOOT are ignored.
//   Selection: winner = lowest index i with redir_valid[i]=1.
//   RUN, stall=0: winner exists -> pc <= its target (latency 1: request at edge N, pc=target
//     after edge N). No winner -> pc <= pc + PC_STEP, modulo 2^XLEN (FFFF_FFFC+4 -> 0000_0000).
//   RUN, stall=1: pc held. Winner exists -> latch target + index into pending buffer,
//     redir_pending=1, -> HOLD. No winner -> stay RUN.
//   HOLD, stall=1: pc held. New winner with index < pending index replaces buffer;
//     equal/higher index ignored (a same-channel re-request does not update the buffer).
//   HOLD, stall=0: new winner with index < pending index -> pc <= new target; else
//     pc <= pending target. Buffer cleared, redir_pending=0, -> RUN. Sequential increment
//     never occurs on the release edge.
//   pc_valid=1 in RUN and HOLD; stall does not clear pc_valid.
//   Redirect and stall that rise on the same edge: treated as stall=1 (buffered, not applied).
// CONFIGURATION
//   IF_PC_ALIGN_CHECK_EN defined: any redirect target applied to pc with target[1:0]!=0 is
//     replaced by TRAP_VECTOR, and misalign_err=1 for exactly the cycle after that edge.
//     Check is made when the target is applied (immediate or on HOLD release), not when buffered.
//   Not defined: targets applied unmodified; misalign_err tied to 0; port list unchanged.
// TESTING
//   1 reset 3 cycles, release, stall=0 -> pc 0x0 (pc_valid 0), then 0x0 (pc_valid 1), 0x4, 0x8.
//   2 pc=0x40, redir_valid=3'b110 tgt1=0x200 tgt2=0x300, one cycle -> next pc=0x200, then 0x204.
//   3 pc=0x80, stall=1 4 cycles; cyc1 ch2 tgt 0x300; cyc3 ch0 tgt 0x500 -> pc=0x80 held,
//     redir_pending=1; release -> pc=0x500, then 0x504.
//   4 pc=0xFFFF_FFF8, no redirects -> 0xFFFF_FFFC, 0x0000_0000.
//   5 HOLD with pending ch1, reset pulsed 1 cycle -> pc=0x0, redir_pending=0, BOOT sequence restarts.
//   6 (IF_PC_ALIGN_CHECK_EN) ch1 tgt 0x202 -> pc=0x100, misalign_err=1 one cycle; undefined -> pc=0x202, err 0.

Source files
------------

// File: rtl/if_pc_sequencer.sv
// Fetch-stage PC register with prioritised redirect channels, stall buffering and optional
// misaligned-target trapping (enable with `define IF_PC_ALIGN_CHECK_EN).
module if_pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              NUM_REDIR    = 3,
  parameter int              PC_STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target,
  output logic [XLEN-1:0]           pc,
  output logic                      pc_valid,
  output logic                      redir_pending,
  output logic                      misalign_err
);

  localparam int IDX_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;

`ifdef IF_PC_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK = 1'b1;
`else
  localparam logic ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [XLEN-1:0]  win_tgt;
  logic             win_beats_pend;
  logic [XLEN:0]    applied;

  // Returns {trap_flag, pc_value} for a redirect target that is about to reach the PC.
  function automatic logic [XLEN:0] apply_target(input logic [XLEN-1:0] tgt);
    if (ALIGN_CHECK && (tgt[1:0] != 2'b00)) return {1'b1, TRAP_VECTOR};
    return {1'b0, tgt};
  endfunction

  // Scan from the lowest-priority channel upwards so the lowest index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_tgt   = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_tgt   = redir_target[i*XLEN +: XLEN];
      end
    end
  end

  assign win_beats_pend = win_found && (win_idx < pend_idx_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    err_d      = 1'b0;
    pend_tgt_d = pend_tgt_q;
    pend_idx_d = pend_idx_q;
    applied    = '0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (stall) begin
          if (win_found) begin
            pend_tgt_d = win_tgt;
            pend_idx_d = win_idx;
            state_d    = HOLD;
          end
        end else if (win_found) begin
          applied = apply_target(win_tgt);
          pc_d    = applied[XLEN-1:0];
          err_d   = applied[XLEN];
        end else begin
          pc_d = pc_q + XLEN'(PC_STEP);
        end
      end
      HOLD: begin
        if (stall) begin
          if (win_beats_pend) begin
            pend_tgt_d = win_tgt;
            pend_idx_d = win_idx;
          end
        end else begin
          applied    = apply_target(win_beats_pend ? win_tgt : pend_tgt_q);
          pc_d       = applied[XLEN-1:0];
          err_d      = applied[XLEN];
          pend_idx_d = '0;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Control and PC registers: reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Pending buffer contents are only observed in HOLD, which reset leaves.
  always_ff @(posedge clk) begin
    pend_tgt_q <= pend_tgt_d;
    pend_idx_q <= pend_idx_d;
  end

  assign pc            = pc_q;
  assign pc_valid      = (state_q != BOOT);
  assign redir_pending = (state_q == HOLD);
  assign misalign_err  = err_q;

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Scoreboard bench for if_pc_sequencer: directed scenarios plus random traffic against a
// behavioural next-PC model.
module tb_if_pc_sequencer;
  localparam int XLEN = 32;
  localparam int NR   = 3;

`ifdef IF_PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 stall = 1'b0;
  logic [NR-1:0]        redir_valid = '0;
  logic [NR*XLEN-1:0]   redir_target = '0;
  logic [XLEN-1:0]      pc;
  logic                 pc_valid, redir_pending, misalign_err;

  always #5 clk = ~clk;

  if_pc_sequencer #(
    .XLEN(XLEN), .NUM_REDIR(NR), .PC_STEP(4),
    .RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .pc(pc), .pc_valid(pc_valid), .redir_pending(redir_pending),
    .misalign_err(misalign_err)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        pend;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: "booted" flag, optional pending redirect, current PC.
  bit          m_boot = 1'b1;
  bit          m_hold = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_ptgt = 32'h0;
  int          m_pidx = 0;

  task automatic model_apply(input logic [31:0] t);
    if (ALIGN && t[1:0] != 2'b00) begin
      m_pc  = 32'h0000_0100;
      m_err = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic [2:0] v,
                      input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    logic [31:0] tg [3];
    int w;
    @(negedge clk);
    reset = rst; stall = st; redir_valid = v; redir_target = {t2, t1, t0};
    tg[0] = t0; tg[1] = t1; tg[2] = t2;
    w = -1;
    for (int i = 0; i < NR; i++) if (v[i] && w < 0) w = i;
    m_err = 1'b0;
    if (rst) begin
      m_boot = 1'b1; m_hold = 1'b0; m_pc = 32'h0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_hold) begin
      if (st) begin
        if (w >= 0) begin m_hold = 1'b1; m_pidx = w; m_ptgt = tg[w]; end
      end else if (w >= 0) begin
        model_apply(tg[w]);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (w >= 0 && w < m_pidx) begin m_pidx = w; m_ptgt = tg[w]; end
      if (!st) begin model_apply(m_ptgt); m_hold = 1'b0; end
    end
    sb.push_back('{pc: m_pc, vld: !m_boot, pend: m_hold, err: m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
  endtask

  // Direct comparison of the DUT against a literal, sampled 2 time units after the edge.
  task automatic check_now(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  task automatic after_edge();
    @(posedge clk); #2;
  endtask

  // Monitor: pops one expectation per presented cycle and compares every output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (pc !== e.pc || pc_valid !== e.vld || redir_pending !== e.pend || misalign_err !== e.err) begin
          n_fail++;
          $display("FAIL sb t=%0t: pc=%h vld=%b pend=%b err=%b expected pc=%h vld=%b pend=%b err=%b",
                   $time, pc, pc_valid, redir_pending, misalign_err, e.pc, e.vld, e.pend, e.err);
        end
      end
    end
  end

  initial begin
    logic [2:0]  v;
    logic [31:0] t [3];
    bit          st;

    // 1: reset, boot at reset vector, then sequential
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    after_edge();
    check_now("reset_pc", pc, 32'h0);
    check_now("reset_vld", {31'b0, pc_valid}, 32'h0);
    idle(1); after_edge();
    check_now("boot_vld", {31'b0, pc_valid}, 32'h1);
    check_now("boot_pc", pc, 32'h0);
    idle(2); after_edge();
    check_now("seq_pc", pc, 32'h8);

    // 2: priority among simultaneous redirects
    step(1'b0, 1'b0, 3'b001, 32'h40, 32'h0, 32'h0);
    step(1'b0, 1'b0, 3'b110, 32'h0, 32'h200, 32'h300);
    after_edge();
    check_now("prio_pc", pc, 32'h200);
    idle(1); after_edge();
    check_now("prio_seq", pc, 32'h204);

    // 3: buffered redirect replaced by higher priority during stall
    step(1'b0, 1'b0, 3'b001, 32'h80, 32'h0, 32'h0);
    step(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h300);
    step(1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 3'b001, 32'h500, 32'h0, 32'h0);
    step(1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0);
    after_edge();
    check_now("hold_pc", pc, 32'h80);
    check_now("hold_pend", {31'b0, redir_pending}, 32'h1);
    idle(1); after_edge();
    check_now("release_pc", pc, 32'h500);
    check_now("release_pend", {31'b0, redir_pending}, 32'h0);
    idle(1); after_edge();
    check_now("release_seq", pc, 32'h504);

    // Same-channel re-request does not replace; higher priority at release wins
    step(1'b0, 1'b1, 3'b010, 32'h0, 32'h700, 32'h0);
    step(1'b0, 1'b1, 3'b010, 32'h0, 32'h800, 32'h0);
    idle(1); after_edge();
    check_now("rereq_pc", pc, 32'h700);
    step(1'b0, 1'b1, 3'b100, 32'h0, 32'h0, 32'h900);
    step(1'b0, 1'b0, 3'b001, 32'hA00, 32'h0, 32'h0);
    after_edge();
    check_now("release_new_win", pc, 32'hA00);

    // 4: wraparound
    step(1'b0, 1'b0, 3'b001, 32'hFFFF_FFF8, 32'h0, 32'h0);
    idle(1); after_edge();
    check_now("wrap_fc", pc, 32'hFFFF_FFFC);
    idle(1); after_edge();
    check_now("wrap_zero", pc, 32'h0);

    // 5: reset while HOLD with a pending redirect; BOOT ignores redirects
    step(1'b0, 1'b1, 3'b010, 32'h0, 32'h600, 32'h0);
    step(1'b1, 1'b1, 3'b010, 32'h0, 32'h600, 32'h0);
    after_edge();
    check_now("rst_hold_pc", pc, 32'h0);
    check_now("rst_hold_pend", {31'b0, redir_pending}, 32'h0);
    step(1'b0, 1'b0, 3'b001, 32'h123C, 32'h0, 32'h0);
    after_edge();
    check_now("boot_ignore", pc, 32'h0);
    idle(1); after_edge();
    check_now("reboot_seq", pc, 32'h4);

    // 6: misaligned target
    step(1'b0, 1'b0, 3'b010, 32'h0, 32'h202, 32'h0);
    after_edge();
    check_now("mis_pc", pc, ALIGN ? 32'h100 : 32'h202);
    check_now("mis_err", {31'b0, misalign_err}, {31'b0, ALIGN});
    idle(1); after_edge();
    check_now("mis_err_clr", {31'b0, misalign_err}, 32'h0);

    // Random traffic
    st = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) st = ~st;
      for (int i = 0; i < NR; i++) begin
        v[i] = ($urandom_range(0, 5) == 0);
        t[i] = $urandom;
        if ($urandom_range(0, 7) != 0) t[i][1:0] = 2'b00;
      end
      step($urandom_range(0, 99) == 0, st, v, t[0], t[1], t[2]);
    end

    idle(2);
    repeat (3) @(posedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
